// File: rtl/rn_fl_ckpt_pkg.sv
// Shared configuration for the rename free list: PR width default and lane-count limits.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.

`ifndef NCPU_PRF_AW
`define NCPU_PRF_AW 6
`endif

package rn_fl_ckpt_pkg;

    // Default physical register index width (N_PRF = 1 << PRF_AW_DFLT).
    localparam int PRF_AW_DFLT = `NCPU_PRF_AW;

    // Issue and commit widths are given as log2 and are legal in 0..LANE_LOG_MAX.
    localparam int LANE_LOG_MAX = 2;

    // Width of the per-PR running free count in the selector; it saturates at IW <= 4.
    localparam int SEL_RANK_W = LANE_LOG_MAX + 1;

    // Which source updates the live free list this cycle, in priority order.
    typedef enum logic [1:0] {
        MODE_NORMAL   = 2'd0,
        MODE_RESTORE  = 2'd1,
        MODE_ROLLBACK = 2'd2
    } fl_mode_e;

    // Index widths are never allowed to collapse to zero bits.
    function automatic int max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/rn_fl_ckpt_if.sv
// Rename/commit side bundle of the free list: allocation lanes, checkpoint control, commit lanes.
// Latency: wires only.
// Backpressure: fl_stall_req from the slave holds rename; commit lanes are never stalled.

interface rn_fl_ckpt_if
    import rn_fl_ckpt_pkg::*;
#(
    parameter int CONFIG_P_ISSUE_WIDTH  = 1,
    parameter int CONFIG_P_COMMIT_WIDTH = 1,
    parameter int CONFIG_P_PRF_AW       = PRF_AW_DFLT,
    parameter int CONFIG_P_N_CKPT       = 2
);
    localparam int IW    = 1 << CONFIG_P_ISSUE_WIDTH;
    localparam int CW    = 1 << CONFIG_P_COMMIT_WIDTH;
    localparam int AW    = CONFIG_P_PRF_AW;
    localparam int NC_AW = CONFIG_P_N_CKPT;
    localparam int IW_AW = max1(CONFIG_P_ISSUE_WIDTH);

    logic [IW-1:0]      pop;
    logic [IW-1:0]      lrd_we;
    logic [IW*AW-1:0]   fl_prd;
    logic               fl_stall_req;
    logic               ckpt_take;
    logic [IW_AW-1:0]   ckpt_lane;
    logic [NC_AW-1:0]   ckpt_id;
    logic               ckpt_full;
    logic               ckpt_release;
    logic               rb_ckpt;
    logic [NC_AW-1:0]   rb_ckpt_id;
    logic               rollback;
    logic [CW-1:0]      cmt_fire;
    logic [CW-1:0]      cmt_prd_we;
    logic [CW*AW-1:0]   cmt_prd;
    logic [CW*AW-1:0]   cmt_pfree;
    logic               fl_err;

    modport master (
        output pop, lrd_we, ckpt_take, ckpt_lane, ckpt_release, rb_ckpt, rb_ckpt_id,
               rollback, cmt_fire, cmt_prd_we, cmt_prd, cmt_pfree,
        input  fl_prd, fl_stall_req, ckpt_id, ckpt_full, fl_err
    );

    modport slave (
        input  pop, lrd_we, ckpt_take, ckpt_lane, ckpt_release, rb_ckpt, rb_ckpt_id,
               rollback, cmt_fire, cmt_prd_we, cmt_prd, cmt_pfree,
        output fl_prd, fl_stall_req, ckpt_id, ckpt_full, fl_err
    );

endinterface

// File: rtl/rn_fl_sel.sv
// IW-lane free-PR selector: lane j gets the lowest free PR not claimed by a lower writing lane.
// Latency: purely combinational.
// Backpressure: none; gs_o[j]=0 tells the caller lane j has no PR available.

module rn_fl_sel
    import rn_fl_ckpt_pkg::*;
#(
    parameter int IW     = 2,
    parameter int PRF_AW = 6
) (
    input  logic [(1<<PRF_AW)-1:0] free_i,
    input  logic [IW-1:0]          lrd_we_i,
    output logic [IW*PRF_AW-1:0]   prd_o,
    output logic [IW-1:0]          gs_o
);
    localparam int N_PRF = 1 << PRF_AW;
    localparam int RK_W  = SEL_RANK_W;

    logic [RK_W-1:0] pfx  [N_PRF];
    logic [RK_W-1:0] rank [IW];

    // Number of free PRs below each index, saturated at IW (nothing past that can be picked).
    always_comb begin
        logic [RK_W-1:0] run;
        run = '0;
        for (int i = 0; i < N_PRF; i++) begin
            pfx[i] = run;
            if (free_i[i] && (run < RK_W'(IW))) run = run + 1'b1;
        end
    end

    // Lane j wants the free PR whose rank equals the number of writing lanes below it.
    always_comb begin
        for (int j = 0; j < IW; j++) begin
            rank[j] = '0;
            for (int k = 0; k < IW; k++)
                if (k < j) rank[j] = rank[j] + RK_W'(lrd_we_i[k]);
        end
    end

    // Every lane matches against the prefix counts in parallel; at most one PR hits per lane.
    always_comb begin
        prd_o = '0;
        gs_o  = '0;
        for (int j = 0; j < IW; j++) begin
            for (int i = 0; i < N_PRF; i++) begin
                if (free_i[i] && (pfx[i] == rank[j])) begin
                    prd_o[j*PRF_AW +: PRF_AW] = prd_o[j*PRF_AW +: PRF_AW] | PRF_AW'(i);
                    gs_o[j] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rn_fl_ckpt.sv
// Rename free list with architectural copy and a circular bank of branch checkpoints.
// Latency: offers are combinational; alloc/free/checkpoint/restore take effect next cycle.
// Backpressure: fl_stall_req when a writing lane has no PR or a take finds the bank full.
// Optional NCPU_FL_CHK_EN adds a sticky consistency checker on fl_err.

module rn_fl_ckpt
    import rn_fl_ckpt_pkg::*;
#(
    parameter int CONFIG_P_ISSUE_WIDTH  = 1,
    parameter int CONFIG_P_COMMIT_WIDTH = 1,
    parameter int CONFIG_P_PRF_AW       = PRF_AW_DFLT,
    parameter int CONFIG_P_N_CKPT       = 2
) (
    input  logic          clk,
    input  logic          rst,
    rn_fl_ckpt_if.slave   bus
);
    localparam int IW    = 1 << CONFIG_P_ISSUE_WIDTH;
    localparam int CW    = 1 << CONFIG_P_COMMIT_WIDTH;
    localparam int AW    = CONFIG_P_PRF_AW;
    localparam int N_PRF = 1 << AW;
    localparam int NC    = 1 << CONFIG_P_N_CKPT;
    localparam int NC_AW = CONFIG_P_N_CKPT;
    localparam int IW_AW = max1(CONFIG_P_ISSUE_WIDTH);

    typedef logic [N_PRF-1:0] map_t;
    localparam map_t RST_MAP = {{(N_PRF-1){1'b1}}, 1'b0};   // PR0 is never free

    map_t             fl_q, fl_d;
    map_t             afl_q, afl_d;
    map_t             snap_q [NC];
    map_t             snap_d [NC];
    logic [NC_AW-1:0] wp_q, wp_d;
    logic [NC_AW:0]   cnt_q, cnt_d;

    logic [IW*AW-1:0] sel_prd;
    logic [IW-1:0]    sel_gs;
    map_t             free_m, aclr_m, alloc_m, alloc_pre_m;
    logic             ckpt_full, lane_stall, stall, take_acc, rel_acc;
    logic [NC_AW-1:0] oldest, rb_dist;
    logic             rb_live;
    fl_mode_e         mode;

    rn_fl_sel #(.IW(IW), .PRF_AW(AW)) u_sel (
        .free_i   (fl_q),
        .lrd_we_i (bus.lrd_we),
        .prd_o    (sel_prd),
        .gs_o     (sel_gs)
    );

    // A full bank only stalls a take when no slot is being retired in the same cycle.
    always_comb begin
        ckpt_full  = (cnt_q == (NC_AW+1)'(NC));
        lane_stall = |(bus.lrd_we & ~sel_gs);
        stall      = lane_stall | (bus.ckpt_take & ckpt_full & ~bus.ckpt_release);
        take_acc   = bus.ckpt_take & ~stall;
        rel_acc    = bus.ckpt_release & (cnt_q != '0);
        oldest     = wp_q - cnt_q[NC_AW-1:0];
        rb_dist    = bus.rb_ckpt_id - oldest;
        rb_live    = ({1'b0, rb_dist} < cnt_q);
        if (bus.rollback)     mode = MODE_ROLLBACK;
        else if (bus.rb_ckpt) mode = MODE_RESTORE;
        else                  mode = MODE_NORMAL;
    end

    assign bus.fl_prd       = sel_prd;
    assign bus.fl_stall_req = stall;
    assign bus.ckpt_full    = ckpt_full;
    assign bus.ckpt_id      = wp_q;

    // Commit frees (stale PRs) and aFL clears (newly architectural PRs); PR0 can never become free.
    always_comb begin
        free_m = '0;
        aclr_m = '0;
        for (int j = 0; j < CW; j++) begin
            if (bus.cmt_fire[j] & bus.cmt_prd_we[j]) begin
                free_m[bus.cmt_pfree[j*AW +: AW]] = 1'b1;
                aclr_m[bus.cmt_prd[j*AW +: AW]]   = 1'b1;
            end
        end
        free_m[0] = 1'b0;
    end

    // PRs consumed this cycle, plus the subset up to and including the branch lane for the snapshot.
    always_comb begin
        alloc_m     = '0;
        alloc_pre_m = '0;
        for (int j = 0; j < IW; j++) begin
            if (bus.pop[j] & bus.lrd_we[j] & sel_gs[j]) begin
                alloc_m[sel_prd[j*AW +: AW]] = 1'b1;
                if (IW_AW'(j) <= bus.ckpt_lane) alloc_pre_m[sel_prd[j*AW +: AW]] = 1'b1;
            end
        end
    end

    // Next state: commits always land in aFL and snapshots; the mode picks the live FL source.
    always_comb begin
        afl_d = (afl_q | free_m) & ~aclr_m;
        fl_d  = (fl_q & ~alloc_m) | free_m;
        wp_d  = wp_q;
        cnt_d = cnt_q;
        for (int s = 0; s < NC; s++) snap_d[s] = snap_q[s] | free_m;
        case (mode)
            MODE_ROLLBACK: begin
                fl_d  = afl_d;
                cnt_d = '0;
            end
            MODE_RESTORE: begin
                fl_d  = snap_q[bus.rb_ckpt_id] | free_m;
                wp_d  = bus.rb_ckpt_id + 1'b1;
                cnt_d = {1'b0, rb_dist} + 1'b1;
            end
            default: begin
                if (take_acc) begin
                    snap_d[wp_q] = (fl_q & ~alloc_pre_m) | free_m;
                    wp_d         = wp_q + 1'b1;
                end
                cnt_d = cnt_q + (NC_AW+1)'(take_acc) - (NC_AW+1)'(rel_acc);
            end
        endcase
    end

    // State registers with synchronous reset to "everything but PR0 free".
    always_ff @(posedge clk) begin
        if (rst) begin
            fl_q  <= RST_MAP;
            afl_q <= RST_MAP;
            for (int s = 0; s < NC; s++) snap_q[s] <= RST_MAP;
            wp_q  <= '0;
            cnt_q <= '0;
        end else begin
            fl_q  <= fl_d;
            afl_q <= afl_d;
            for (int s = 0; s < NC; s++) snap_q[s] <= snap_d[s];
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef NCPU_FL_CHK_EN
    logic err_q, err_d;

    // Any bookkeeping inconsistency latches the error until reset.
    always_comb begin
        err_d = err_q;
        for (int j = 0; j < CW; j++) begin
            if (bus.cmt_fire[j] & bus.cmt_prd_we[j]) begin
                if (bus.cmt_pfree[j*AW +: AW] == '0)    err_d = 1'b1;
                if (fl_q[bus.cmt_pfree[j*AW +: AW]])    err_d = 1'b1;
            end
        end
        if (mode == MODE_NORMAL) begin
            for (int j = 0; j < IW; j++)
                if (bus.pop[j] & bus.lrd_we[j] & ~(sel_gs[j] & fl_q[sel_prd[j*AW +: AW]]))
                    err_d = 1'b1;
        end
        if (bus.ckpt_release && (cnt_q == '0))     err_d = 1'b1;
        if ((mode == MODE_RESTORE) && !rb_live)    err_d = 1'b1;
    end

    // Sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign bus.fl_err = err_q;
`else
    logic unused_rb_live;
    assign unused_rb_live = rb_live;
    assign bus.fl_err     = 1'b0;
`endif

endmodule

// File: tb/tb_rn_fl_ckpt.sv
// Directed bench for rn_fl_ckpt (IW=2, CW=2, 64 PRs, 4 checkpoints).
// Stimulus schedules expected observations per cycle into a queue; a negedge monitor checks them.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.

module tb_rn_fl_ckpt;
    import rn_fl_ckpt_pkg::*;

    localparam int K_PRD0  = 0;
    localparam int K_PRD1  = 1;
    localparam int K_STALL = 2;
    localparam int K_FULL  = 3;
    localparam int K_ID    = 4;
    localparam int K_ERR   = 5;

`ifdef NCPU_FL_CHK_EN
    localparam int ERR_EXP = 1;
`else
    localparam int ERR_EXP = 0;
`endif

    typedef struct {
        int    cyc;
        int    kind;
        int    val;
        string name;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    exp_t  sbq [$];
    exp_t  mon_e;
    int    act;

    rn_fl_ckpt_if #(.CONFIG_P_ISSUE_WIDTH(1), .CONFIG_P_COMMIT_WIDTH(1),
                    .CONFIG_P_PRF_AW(6), .CONFIG_P_N_CKPT(2)) ifc ();

    rn_fl_ckpt #(.CONFIG_P_ISSUE_WIDTH(1), .CONFIG_P_COMMIT_WIDTH(1),
                 .CONFIG_P_PRF_AW(6), .CONFIG_P_N_CKPT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int observe(input int k);
        case (k)
            K_PRD0:  return int'(ifc.fl_prd[5:0]);
            K_PRD1:  return int'(ifc.fl_prd[11:6]);
            K_STALL: return int'(ifc.fl_stall_req);
            K_FULL:  return int'(ifc.ckpt_full);
            K_ID:    return int'(ifc.ckpt_id);
            default: return int'(ifc.fl_err);
        endcase
    endfunction

    // Monitor: pop every expectation scheduled for the current cycle and compare.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            mon_e = sbq.pop_front();
            act   = observe(mon_e.kind);
            checks++;
            if (mon_e.cyc != cyc || act != mon_e.val) begin
                errors++;
                $display("FAIL %s (cycle %0d): got %0d, expected %0d", mon_e.name, cyc, act, mon_e.val);
            end
        end
    end

    task automatic chk(input int k, input int v, input string nm);
        exp_t e;
        e.cyc = cyc; e.kind = k; e.val = v; e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic prd(input int a, input int b, input string nm);
        chk(K_PRD0, a, {nm, "_prd0"});
        chk(K_PRD1, b, {nm, "_prd1"});
    endtask

    task automatic idle();
        ifc.pop = '0; ifc.lrd_we = '0; ifc.ckpt_take = 1'b0; ifc.ckpt_lane = '0;
        ifc.ckpt_release = 1'b0; ifc.rb_ckpt = 1'b0; ifc.rb_ckpt_id = '0; ifc.rollback = 1'b0;
        ifc.cmt_fire = '0; ifc.cmt_prd_we = '0; ifc.cmt_prd = '0; ifc.cmt_pfree = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic lanes(input logic [1:0] we, input logic [1:0] p);
        ifc.lrd_we = we;
        ifc.pop    = p;
    endtask

    task automatic commit0(input int new_pr, input int stale_pr);
        ifc.cmt_fire   = 2'b01;
        ifc.cmt_prd_we = 2'b01;
        ifc.cmt_prd    = {6'd0, 6'(new_pr)};
        ifc.cmt_pfree  = {6'd0, 6'(stale_pr)};
    endtask

    task automatic take(input logic lane);
        ifc.ckpt_take = 1'b1;
        ifc.ckpt_lane = lane;
    endtask

    initial begin
        // Reset state and sequential allocation.
        do_reset();
        lanes(2'b11, 2'b00); prd(1, 2, "rst"); chk(K_STALL, 0, "rst_stall");
        chk(K_FULL, 0, "rst_full"); chk(K_ID, 0, "rst_id"); chk(K_ERR, 0, "rst_err");
        tick();
        for (int k = 0; k < 3; k++) begin
            lanes(2'b11, 2'b11); prd(1 + 2*k, 2 + 2*k, "alloc"); tick();
        end
        // Drain 7..62, leaving only PR63.
        for (int k = 0; k < 28; k++) begin
            lanes(2'b11, 2'b11); chk(K_PRD0, 7 + 2*k, "drain_prd0"); tick();
        end
        lanes(2'b11, 2'b00); commit0(10, 9);
        chk(K_PRD0, 63, "last_pr"); chk(K_STALL, 1, "empty_stall"); tick();
        lanes(2'b11, 2'b00); prd(9, 63, "freed9"); chk(K_STALL, 0, "freed9_stall"); tick();

        // Checkpoint restore, then fill the bank and wrap with take+release.
        do_reset();
        lanes(2'b11, 2'b11); take(1'b0); prd(1, 2, "ck0"); chk(K_ID, 0, "ck0_id"); tick();
        lanes(2'b11, 2'b11); prd(3, 4, "ck1"); tick();
        lanes(2'b11, 2'b00); ifc.rb_ckpt = 1'b1; ifc.rb_ckpt_id = 2'd0; prd(5, 6, "rb_cyc"); tick();
        lanes(2'b11, 2'b00); prd(2, 3, "restored"); chk(K_ID, 1, "rb_wp"); chk(K_FULL, 0, "rb_full"); tick();
        for (int k = 0; k < 3; k++) begin
            take(1'b0); chk(K_ID, 1 + k, "fill_id"); chk(K_FULL, 0, "fill_full"); chk(K_STALL, 0, "fill_stall"); tick();
        end
        take(1'b0); chk(K_FULL, 1, "full"); chk(K_STALL, 1, "full_stall"); chk(K_ID, 0, "full_id"); tick();
        take(1'b0); ifc.ckpt_release = 1'b1;
        chk(K_STALL, 0, "take_rel_stall"); chk(K_ID, 0, "take_rel_id"); chk(K_FULL, 1, "take_rel_full"); tick();
        chk(K_FULL, 1, "after_wrap_full"); chk(K_ID, 1, "after_wrap_id"); tick();

        // Commit updates live snapshot and aFL; restore, then full rollback.
        do_reset();
        lanes(2'b11, 2'b11); prd(1, 2, "rbk_a"); tick();
        lanes(2'b11, 2'b11); prd(3, 4, "rbk_b"); tick();
        lanes(2'b01, 2'b01); chk(K_PRD0, 5, "rbk_c_prd0"); tick();
        take(1'b0); chk(K_ID, 0, "rbk_take_id"); tick();
        lanes(2'b11, 2'b00); commit0(5, 1); prd(6, 7, "rbk_cmt"); tick();
        lanes(2'b11, 2'b00); ifc.rb_ckpt = 1'b1; ifc.rb_ckpt_id = 2'd0; prd(1, 6, "rbk_free1"); tick();
        lanes(2'b11, 2'b00); prd(1, 6, "snap_has1"); chk(K_ID, 1, "snap_wp"); tick();
        lanes(2'b11, 2'b00); ifc.rollback = 1'b1; prd(1, 6, "rollback_cyc"); tick();
        lanes(2'b11, 2'b11); prd(1, 2, "afl_a"); tick();
        lanes(2'b11, 2'b11); prd(3, 4, "afl_b"); tick();
        lanes(2'b10, 2'b00); chk(K_PRD1, 6, "afl_skip5"); chk(K_FULL, 0, "rbk_full");
        chk(K_ID, 1, "rbk_wp_kept"); tick();

        // Freeing an already-free PR.
        do_reset();
        commit0(8, 7); chk(K_ERR, 0, "err_pre"); tick();
        chk(K_ERR, ERR_EXP, "err_set"); tick();
        chk(K_ERR, ERR_EXP, "err_hold"); tick();
        do_reset();
        chk(K_ERR, 0, "err_cleared"); tick();

        for (int w = 0; w < 10 && sbq.size() > 0; w++) @(posedge clk);
        if (sbq.size() > 0) begin
            $display("FAIL drain: got %0d unchecked expectations, expected 0", sbq.size());
            errors += sbq.size();
            checks += sbq.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
